// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style UART receive path driven by the shared oversampling tick.
// Recovers start / SIZE_DATA data bits (LSB first) / stop frames, writes good bytes
// to the RX FIFO with a one-cycle strobe and flags framing and overrun errors.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote around mid-bit).
module uart_receiver #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx_en,
    input  logic                 i_rx_serial,
    input  logic                 i_fifo_full,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_rx_busy
);

    localparam int CW  = $clog2(OVER_SAMPLE);
    localparam int IW  = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
    localparam int MID = OVER_SAMPLE / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DEC = MID + 1;
`else
    localparam int DEC = MID;
`endif
    localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVER_SAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE_DATA - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic [CW-1:0]         count_q, count_d;
    logic [IW-1:0]         index_q, index_d;
    logic [SIZE_DATA-1:0]  shift_q, shift_d;
    logic [SIZE_DATA-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  rxs;
    logic                  bit_val;
    logic                  dec_tick;
    logic                  last_tick;

    assign rxs       = sync_q[1];
    assign dec_tick  = i_stick && (count_q == CNT_DEC);
    assign last_tick = i_stick && (count_q == CNT_LAST);

    // Two-stage synchronizer for the serial line plus the previous-value register for edge detection
    always_comb begin
        sync_d = {sync_q[0], i_rx_serial};
        prev_d = rxs;
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q, vote_d;

    // Capture the two samples preceding the decision tick; the third is the live line value
    always_comb begin
        vote_d = vote_q;
        if (i_stick && (count_q == CW'(MID - 1))) begin
            vote_d[0] = rxs;
        end
        if (i_stick && (count_q == CW'(MID))) begin
            vote_d[1] = rxs;
        end
    end

    // Vote sample register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
`else
    assign bit_val = rxs;
`endif

    // Frame FSM next-state, bit counters, shift register and result pulses
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if ((state_q != IDLE) && i_stick) begin
            count_d = last_tick ? '0 : count_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_rx_en && prev_q && !rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (dec_tick && bit_val) begin
                    state_d = IDLE;
                end else if (last_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (dec_tick) begin
                    shift_d = {bit_val, shift_q[SIZE_DATA-1:1]};
                end
                if (last_tick) begin
                    if (index_q == IDX_LAST) begin
                        index_d = '0;
                        state_d = STOP;
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end
            end
            STOP: begin
                if (dec_tick) begin
                    state_d = IDLE;
                    if (bit_val) begin
                        if (i_fifo_full) begin
                            ovr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && !i_rx_en) begin
            state_d = IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        if (state_d == IDLE) begin
            count_d = '0;
            index_d = '0;
        end
    end

    // State, datapath and output pulse registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            count_q <= '0;
            index_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            index_q <= index_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver with a scoreboard of expected pulses.
module tb_uart_receiver;

    localparam int OS       = 16;
    localparam int BIT_CLKS = OS * 4;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_stick;
    logic       i_rx_en;
    logic       i_rx_serial;
    logic       i_fifo_full;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_rx_busy;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 3;

    uart_receiver #(.SIZE_DATA(8), .OVER_SAMPLE(OS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_stick     (i_stick),
        .i_rx_en     (i_rx_en),
        .i_rx_serial (i_rx_serial),
        .i_fifo_full (i_fifo_full),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_rx_busy   (o_rx_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Oversample tick: one clock in four
    initial i_stick = 1'b0;
    always @(negedge i_clk) begin
        phase   = (phase + 1) % 4;
        i_stick = (phase == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            i_rx_serial = v;
            wait_clks(1);
        end
    endtask

    task automatic push_exp(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    // Full frame aligned to a tick; optional 3-clock glitch around the mid tick of data bit 2
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic glitch);
        logic [9:0] frame;
        logic       v;
        frame = {stop, data, 1'b0};
        while (phase != 0) wait_clks(1);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                v = frame[b];
                if (glitch && b == 3 && c >= 33 && c <= 35) v = ~v;
                i_rx_serial = v;
                wait_clks(1);
            end
        end
    endtask

    // Scoreboard monitor: every result pulse must match the next expected event
    always @(negedge i_clk) begin : monitor
        exp_t e;
        int   kind;
        if (i_rst_n === 1'b1 && (o_rx_valid | o_frame_err | o_overrun)) begin
            check("one_pulse", 32'(o_rx_valid) + 32'(o_frame_err) + 32'(o_overrun), 1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, o_rx_valid, o_frame_err, o_overrun}, 0);
            end else begin
                e    = sb.pop_front();
                kind = o_rx_valid ? 0 : (o_frame_err ? 1 : 2);
                check("pulse_kind", kind, e.kind);
                if (e.kind != 1) check("pulse_data", {24'd0, o_rx_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        logic [7:0] glitch_exp;
        i_rst_n     = 1'b0;
        i_rx_en     = 1'b0;
        i_rx_serial = 1'b1;
        i_fifo_full = 1'b0;
        wait_clks(5);
        check("rst_data", {24'd0, o_rx_data}, 0);
        check("rst_valid", o_rx_valid, 0);
        check("rst_ferr", o_frame_err, 0);
        check("rst_ovr", o_overrun, 0);
        check("rst_busy", o_rx_busy, 0);
        i_rst_n = 1'b1;
        i_rx_en = 1'b1;
        wait_clks(20);

        $display("[TB] good frame 0xA5");
        push_exp(0, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_sb_empty", sb.size(), 0);
        check("a5_busy", o_rx_busy, 0);
        check("a5_data", {24'd0, o_rx_data}, 32'hA5);

        $display("[TB] false start");
        drive_line(1'b0, 16);
        check("fs_busy_hi", o_rx_busy, 1);
        drive_line(1'b1, 100);
        check("fs_busy_lo", o_rx_busy, 0);
        check("fs_sb_empty", sb.size(), 0);

        $display("[TB] framing error on 0x3C");
        push_exp(1, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_line(1'b0, 200);
        check("fe_sb_empty", sb.size(), 0);
        check("fe_busy_low_line", o_rx_busy, 0);
        check("fe_data_kept", {24'd0, o_rx_data}, 32'hA5);
        drive_line(1'b1, 64);
        push_exp(0, 8'h96);
        send_frame(8'h96, 1'b1, 1'b0);
        check("fe_next_sb_empty", sb.size(), 0);
        check("fe_next_data", {24'd0, o_rx_data}, 32'h96);

        $display("[TB] overrun on 0x5A");
        i_fifo_full = 1'b1;
        push_exp(2, 8'h96);
        send_frame(8'h5A, 1'b1, 1'b0);
        i_fifo_full = 1'b0;
        check("ovr_sb_empty", sb.size(), 0);
        check("ovr_data_kept", {24'd0, o_rx_data}, 32'h96);

        $display("[TB] back-to-back 0x00 then 0xFF");
        push_exp(0, 8'h00);
        push_exp(0, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("b2b_sb_empty", sb.size(), 0);
        check("b2b_data", {24'd0, o_rx_data}, 32'hFF);

        $display("[TB] glitch on bit 2");
`ifdef UART_RX_MAJORITY_VOTE_EN
        glitch_exp = 8'hA5;
`else
        glitch_exp = 8'hA1;
`endif
        push_exp(0, glitch_exp);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("gl_sb_empty", sb.size(), 0);
        check("gl_data", {24'd0, o_rx_data}, {24'd0, glitch_exp});

        $display("[TB] receiver disabled mid-frame");
        drive_line(1'b0, 64);
        drive_line(1'b1, 40);
        check("en_busy_hi", o_rx_busy, 1);
        i_rx_en = 1'b0;
        wait_clks(2);
        check("en_busy_lo", o_rx_busy, 0);
        drive_line(1'b0, 64);
        drive_line(1'b1, 640);
        i_rx_en = 1'b1;
        wait_clks(10);
        check("en_sb_empty", sb.size(), 0);
        check("en_busy_idle", o_rx_busy, 0);

        $display("[TB] reset mid-frame");
        drive_line(1'b0, 64);
        drive_line(1'b1, 300);
        check("rm_busy_hi", o_rx_busy, 1);
        i_rst_n = 1'b0;
        wait_clks(1);
        check("rm_busy", o_rx_busy, 0);
        check("rm_data", {24'd0, o_rx_data}, 0);
        wait_clks(2);
        i_rst_n = 1'b1;
        drive_line(1'b1, 700);
        check("rm_sb_empty", sb.size(), 0);
        check("rm_busy_idle", o_rx_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter. Recovers 8N1-style frames (start, SIZE_DATA data bits LSB first, one stop bit) from an asynchronous serial line using the shared oversampling tick. Each good byte is written into the RX FIFO through a single-cycle write strobe. Framing and overrun errors are flagged to the UART register block.

## Interface
- SIZE_DATA, 8: data bits per frame.
- OVER_SAMPLE, 16: i_stick ticks per bit period; must be even and at least 8.

- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_stick  input  1  oversample tick, one i_clk cycle wide, OVER_SAMPLE per bit.
- i_rx_en  input  1  receiver enable.
- i_rx_serial  input  1  asynchronous serial line; idles high.
- i_fifo_full  input  1  RX FIFO full.
- o_rx_data  output  SIZE_DATA  received byte; valid with o_rx_valid, held until the next frame completes.
- o_rx_valid  output  1  one-cycle FIFO write strobe.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: good frame dropped because the FIFO is full.
- o_rx_busy  output  1  high in any state other than IDLE.

## Operation
- i_rx_serial passes through a 2-flop synchronizer, reset value 1, to produce rxs. A separate previous-value register, reset value 1, supports falling-edge detection.
- count has width $clog2(OVER_SAMPLE). It advances only on i_stick and wraps from OVER_SAMPLE-1 to 0. MID = OVER_SAMPLE/2.
- The decision tick D and the sampled bit value are defined under Configuration.
- States:
  - IDLE: count=0, index=0. Move to START when i_rx_en=1 and rxs falls (previous 1, current 0). A line held low never re-arms the receiver.
  - START: on the tick where count==D, a sample of 1 is a false start and returns to IDLE with no output. On the tick where count==OVER_SAMPLE-1, move to DATA.
  - DATA: on the tick where count==D, shift the sample in at the MSB of the shift register (shift right), so the first bit lands at bit 0. On the tick where count==OVER_SAMPLE-1, increment index. Move to STOP when index==SIZE_DATA-1 wraps.
  - STOP: on the tick where count==D, evaluate the stop bit and return to IDLE immediately. The remainder of the stop bit is not waited out, which leaves margin for resynchronization.
- Stop-bit evaluation:
  - Sample 1 and i_fifo_full=0: load o_rx_data and pulse o_rx_valid.
  - Sample 1 and i_fifo_full=1: pulse o_overrun; o_rx_data is unchanged.
  - Sample 0: pulse o_frame_err; no write.
- i_rx_en deasserted mid-frame: the receiver returns to IDLE on the next clock, discards the partial frame and emits no pulse.

## Timing
- Reset values: o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_rx_busy=0, state=IDLE.
- The synchronizer adds 2 i_clk cycles of latency.
- o_rx_valid, o_frame_err and o_overrun are registered. They assert in the i_clk cycle after the STOP decision tick and last exactly one cycle.
- At most one of the three pulses asserts per frame.
- i_fifo_full is sampled in the same cycle as the STOP decision tick.
- Back-to-back frames are supported: a falling edge arriving one tick after the STOP decision is detected.
- Asynchronous reset mid-frame: all state clears immediately and no pulse is emitted.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined:
  - D = MID+1.
  - Each bit value is the 2-of-3 majority of rxs captured on ticks MID-1, MID and MID+1.
  - The start-bit validation uses the same vote.
- UART_RX_MAJORITY_VOTE_EN undefined:
  - D = MID.
  - Each bit value is the single rxs sample on tick MID.

## Test plan
- OVER_SAMPLE=16, i_stick every 4 clocks. Send 0xA5 with stop=1 -> one o_rx_valid pulse with o_rx_data=0xA5; no error pulses; o_rx_busy returns to 0.
- Line pulsed low for 4 ticks, then high -> false start; no pulse of any kind; state returns to IDLE.
- Frame 0x3C with stop bit driven 0 -> o_frame_err pulses once; no o_rx_valid. The next frame is not received until the line returns high and falls again.
- i_fifo_full=1 during a frame of 0x5A -> o_overrun pulses once; no o_rx_valid; o_rx_data keeps its previous value.
- Frames 0x00 then 0xFF back-to-back, the second start edge one bit after the first stop edge -> two o_rx_valid pulses carrying 0x00 then 0xFF.
- 0xA5 with a single-tick glitch inverting bit 2 on tick MID -> 0xA5 with UART_RX_MAJORITY_VOTE_EN defined, 0xA1 without it.
